// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the EX-stage operand forwarding / load-use hazard unit.
package forward_hazard_unit_pkg;

  localparam int NB_REG = 5;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_WB    = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

endpackage

// File: rtl/forward_hazard_unit_fwd_resolve.sv
// Per-operand forwarding resolver: picks the youngest in-flight producer of src_i.
module fwd_resolve #(
  parameter int NB_REG = forward_hazard_unit_pkg::NB_REG
) (
  input  logic [NB_REG-1:0] src_i,
  input  logic              use_i,
  input  logic              ex_valid_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [NB_REG-1:0] ex_dst_i,
  input  logic              mem_valid_i,
  input  logic              mem_regwrite_i,
  input  logic [NB_REG-1:0] mem_dst_i,
  output logic [1:0]        sel_o
);
  import forward_hazard_unit_pkg::*;

  logic ex_hit;
  logic mem_hit;

  // A load in EX cannot forward yet; the stall logic holds the consumer instead.
  assign ex_hit  = ex_valid_i & ex_regwrite_i & ~ex_memread_i & (ex_dst_i == src_i);
  assign mem_hit = mem_valid_i & mem_regwrite_i & (mem_dst_i == src_i);

  always_comb begin
    sel_o = SEL_REG;
    if (use_i && (src_i != '0)) begin
      if (ex_hit)       sel_o = SEL_EXMEM;
      else if (mem_hit) sel_o = SEL_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use stall control for the EX stage, with a
// shadow EX/MEM destination-tag pipeline and a saturating stall counter.
module forward_hazard_unit #(
  parameter int NB_REG = forward_hazard_unit_pkg::NB_REG,
  parameter int NB_CNT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [NB_REG-1:0] i_id_dst,
  input  logic              i_id_regwrite,
  input  logic              i_id_memread,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [1:0]        o_sel_a,
  output logic [1:0]        o_sel_b,
  output logic [NB_CNT-1:0] o_stall_cnt
);
  import forward_hazard_unit_pkg::*;

  logic              ex_valid_q, ex_valid_d;
  logic [NB_REG-1:0] ex_dst_q, ex_dst_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;
  logic              mem_valid_q;
  logic [NB_REG-1:0] mem_dst_q;
  logic              mem_rw_q;
  logic [1:0]        sel_a_q, sel_a_d;
  logic [1:0]        sel_b_q, sel_b_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  logic       id_live;
  logic       ex_load;
  logic       rs_hit;
  logic       rt_hit;
  logic       stall;
  logic       issue;
  logic [1:0] res_a;
  logic [1:0] res_b;

  // Only a load to a real register in EX can stall the instruction in ID.
  assign id_live = i_id_valid & ~i_flush;
  assign ex_load = ex_valid_q & ex_mr_q & ex_rw_q & (ex_dst_q != '0);
  assign rs_hit  = i_id_use_rs & (i_id_rs == ex_dst_q);
  assign rt_hit  = i_id_use_rt & (i_id_rt == ex_dst_q);
  assign stall   = id_live & ex_load & (rs_hit | rt_hit);
  assign issue   = id_live & ~stall;

  fwd_resolve #(.NB_REG(NB_REG)) u_res_a (
    .src_i          (i_id_rs),
    .use_i          (i_id_use_rs),
    .ex_valid_i     (ex_valid_q),
    .ex_regwrite_i  (ex_rw_q),
    .ex_memread_i   (ex_mr_q),
    .ex_dst_i       (ex_dst_q),
    .mem_valid_i    (mem_valid_q),
    .mem_regwrite_i (mem_rw_q),
    .mem_dst_i      (mem_dst_q),
    .sel_o          (res_a)
  );

  fwd_resolve #(.NB_REG(NB_REG)) u_res_b (
    .src_i          (i_id_rt),
    .use_i          (i_id_use_rt),
    .ex_valid_i     (ex_valid_q),
    .ex_regwrite_i  (ex_rw_q),
    .ex_memread_i   (ex_mr_q),
    .ex_dst_i       (ex_dst_q),
    .mem_valid_i    (mem_valid_q),
    .mem_regwrite_i (mem_rw_q),
    .mem_dst_i      (mem_dst_q),
    .sel_o          (res_b)
  );

  always_comb begin
    ex_valid_d = 1'b0;
    ex_dst_d   = '0;
    ex_rw_d    = 1'b0;
    ex_mr_d    = 1'b0;
    sel_a_d    = SEL_REG;
    sel_b_d    = SEL_REG;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_dst_d   = i_id_dst;
      ex_rw_d    = i_id_regwrite;
      ex_mr_d    = i_id_memread;
      sel_a_d    = res_a;
      sel_b_d    = res_b;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + NB_CNT'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_valid_q  <= 1'b0;
      ex_dst_q    <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= '0;
      mem_rw_q    <= 1'b0;
      sel_a_q     <= SEL_REG;
      sel_b_q     <= SEL_REG;
      cnt_q       <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_dst_q   <= ex_dst_q;
      mem_rw_q    <= ex_rw_q;
      ex_valid_q  <= ex_valid_d;
      ex_dst_q    <= ex_dst_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_stall     = stall;
  assign o_sel_a     = sel_a_q;
  assign o_sel_b     = sel_b_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench: the driver queues hand-computed per-cycle expectations,
// the monitor pops and compares them mid-cycle.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       v, fl, ur, ut, rw, mr;
  logic [4:0] rs, rt, dst;
  logic       stall;
  logic [1:0] sel_a, sel_b;
  logic [1:0] cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       chk;
    int         cyc;
    logic       stall;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  forward_hazard_unit #(.NB_REG(5), .NB_CNT(2)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_id_valid    (v),
    .i_id_rs       (rs),
    .i_id_rt       (rt),
    .i_id_use_rs   (ur),
    .i_id_use_rt   (ut),
    .i_id_dst      (dst),
    .i_id_regwrite (rw),
    .i_id_memread  (mr),
    .i_flush       (fl),
    .o_stall       (stall),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_stall_cnt   (cnt)
  );

  task automatic step(input logic r, iv, ifl, input logic [4:0] irs, irt,
                      input logic iur, iut, input logic [4:0] idst,
                      input logic irw, imr, input logic chk, es,
                      input logic [1:0] ea, eb, ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; v = iv; fl = ifl; rs = irs; rt = irt; ur = iur; ut = iut;
    dst = idst; rw = irw; mr = imr;
    e.chk = chk; e.cyc = cyc; e.stall = es; e.a = ea; e.b = eb; e.cnt = ec;
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input logic es, input logic [1:0] ea, eb, ec);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, es, ea, eb, ec);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          total++;
          if (stall !== e.stall) begin
            bad++;
            $display("FAIL c%0d.stall got=%0d exp=%0d", e.cyc, stall, e.stall);
          end
          total++;
          if (sel_a !== e.a) begin
            bad++;
            $display("FAIL c%0d.sel_a got=%0d exp=%0d", e.cyc, sel_a, e.a);
          end
          total++;
          if (sel_b !== e.b) begin
            bad++;
            $display("FAIL c%0d.sel_b got=%0d exp=%0d", e.cyc, sel_b, e.b);
          end
          total++;
          if (cnt !== e.cnt) begin
            bad++;
            $display("FAIL c%0d.cnt got=%0d exp=%0d", e.cyc, cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    rst = 1; v = 0; fl = 0; rs = 0; rt = 0; ur = 0; ut = 0; dst = 0; rw = 0; mr = 0;
    // c0 reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // c1 reset state
    idle(0, 0, 0, 0);
    // ALU chain: add $3,$1,$2 ; sub $4,$3,$5
    step(0, 1, 0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 3, 5, 1, 1, 4, 1, 0, 1, 0, 0, 0, 0);
    idle(0, 2, 0, 0);
    // distance two: add $3 ; or $7 ; and $8,$6,$3
    step(0, 1, 0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 2, 1, 1, 7, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 6, 3, 1, 1, 8, 1, 0, 1, 0, 0, 0, 0);
    // youngest wins: add $3 ; or $3 ; and $8,$6,$3
    step(0, 1, 0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 6, 3, 1, 1, 8, 1, 0, 1, 0, 0, 0, 0);
    idle(0, 0, 2, 0);
    // load-use: lw $2 ; add $5,$2,$2
    step(0, 1, 0, 1, 2, 1, 0, 2, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 2, 2, 1, 1, 5, 1, 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 2, 2, 1, 1, 5, 1, 0, 1, 0, 0, 0, 1);
    idle(0, 1, 1, 1);
    // $0 producer/consumer, then load to $4 with rt=4 unused
    step(0, 1, 0, 1, 2, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 1, 9, 1, 0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 1, 4, 1, 0, 4, 1, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 1, 4, 1, 0, 10, 1, 0, 1, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    // flush during hazard
    step(0, 1, 0, 1, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 2, 2, 1, 1, 5, 1, 0, 1, 0, 0, 0, 1);
    // add $3,$1,$1 (checks flush bubble selects) ; lw $2,0($3) -> A=10
    step(0, 1, 0, 1, 1, 1, 1, 3, 1, 0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 3, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 1);
    // reset during stall, then reissue
    step(1, 1, 0, 2, 2, 1, 1, 5, 1, 0, 1, 1, 2, 0, 1);
    step(0, 1, 0, 2, 2, 1, 1, 5, 1, 0, 1, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // saturation: chain of dependent loads lw $2,0($2)
    step(0, 1, 0, 1, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 1, 1, 0, 1);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 2);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 1, 1, 0, 2);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 3);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 1, 1, 0, 3);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 3);
    step(0, 1, 0, 2, 0, 1, 0, 2, 1, 1, 1, 1, 1, 0, 3);
    idle(0, 0, 0, 3);
    idle(0, 0, 0, 3);
    // independent operands: add $3 ; add $4 ; x $9,$4,$3 -> A=10 B=01
    step(0, 1, 0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0, 0, 3);
    step(0, 1, 0, 1, 2, 1, 1, 4, 1, 0, 1, 0, 0, 0, 3);
    step(0, 1, 0, 4, 3, 1, 1, 9, 1, 0, 1, 0, 0, 0, 3);
    idle(0, 2, 1, 3);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
